// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-access load/store unit with byte-lane steering, load extension and bus timeout
// Stalls the core from issue until the access completes, then releases it for one commit cycle.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  load,
  input  logic [1:0]  store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          is_load_q, is_load_d;
  logic [2:0]    ld_q, ld_d;
  logic [1:0]    off_q, off_d;

  logic          access, illegal, bad_code;
  logic [1:0]    sz;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new, lane, load_ext;
  logic          stall_c, misalign_c, bus_err_c;

  assign access = rd_en | ~wr_en;

  // sz: 0 byte, 1 halfword, 2 word
  always_comb begin
    sz       = 2'd0;
    bad_code = 1'b0;
    if (rd_en) begin
      case (load)
        3'b000, 3'b011: sz = 2'd0;
        3'b001, 3'b100: sz = 2'd1;
        3'b010:         sz = 2'd2;
        default:        bad_code = 1'b1;
      endcase
    end else begin
      case (store)
        2'b00:   sz = 2'd0;
        2'b01:   sz = 2'd1;
        2'b10:   sz = 2'd2;
        default: bad_code = 1'b1;
      endcase
    end
  end

  assign illegal = bad_code | (rd_en & ~wr_en) | ((sz == 2'd1) & addr[0]) |
                   ((sz == 2'd2) & (addr[1:0] != 2'b00));

  always_comb begin
    case (sz)
      2'd0:    be_new = 4'b0001 << addr[1:0];
      2'd1:    be_new = 4'b0011 << addr[1:0];
      default: be_new = 4'b1111;
    endcase
    if (rd_en)            wdata_new = 32'h0;
    else if (sz == 2'd0)  wdata_new = {4{wdata[7:0]}};
    else if (sz == 2'd1)  wdata_new = {2{wdata[15:0]}};
    else                  wdata_new = wdata;
  end

  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (ld_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_ext = lane;
      3'b011:  load_ext = {24'h0, lane[7:0]};
      3'b100:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    is_load_d   = is_load_q;
    ld_d        = ld_q;
    off_d       = off_q;
    stall_c     = 1'b0;
    misalign_c  = 1'b0;
    bus_err_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && illegal) begin
          misalign_c = 1'b1;
          rdata_d    = 32'h0;
        end else if (access) begin
          stall_c     = 1'b1;
          state_d     = S_REQ;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = ~rd_en;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_be_d    = be_new;
          mem_wdata_d = wdata_new;
          is_load_d   = rd_en;
          ld_d        = load;
          off_d       = addr[1:0];
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // a granted store is complete; a granted load still owes its data
        if (mem_gnt && !is_load_q) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_c = 1'b1;
          rdata_d   = 32'h0;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_c = 1'b1;
          rdata_d   = 32'h0;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      is_load_q   <= 1'b0;
      ld_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      is_load_q   <= is_load_d;
      ld_q        <= ld_d;
      off_q       <= off_d;
    end
  end

  assign stall        = rst_n & stall_c;
  assign misalign_err = rst_n & misalign_c;
  assign bus_err      = rst_n & bus_err_c;
  assign rdata        = rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n, rd_en, wr_en;
  logic [2:0]  load;
  logic [1:0]  store;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign_err, bus_err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .load(load), .store(store),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign_err(misalign_err),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        stall, req, mis, berr, chk_bus, we, chk_rd;
    logic [31:0] addr, wd, rd;
    logic [3:0]  be;
  } exp_t;
  typedef struct {
    int          kind;
    logic [31:0] val;
  } pin_t;

  localparam int P_STALL = 0, P_REQ = 1, P_RD = 2, P_BE = 3, P_ADDR = 4, P_WD = 5, P_WE = 6, P_REQTOT = 7;

  exp_t exp_q[$];
  pin_t pin_q[$];
  int   vecs = 0, miss = 0;
  int   stall_run = 0, stall_len = 0, req_run = 0, req_len = 0, req_total = 0;
  logic [31:0] cap_rd = 32'h0, cap_addr = 32'h0, cap_wd = 32'h0;
  logic [3:0]  cap_be = 4'h0;
  logic        cap_we = 1'b0;

  function automatic exp_t mk(logic s, logic r, logic m, logic b, logic cb, logic we,
                              logic [31:0] ad, logic [3:0] be, logic [31:0] wd, logic cr, logic [31:0] rd);
    exp_t e;
    e.stall = s; e.req = r; e.mis = m; e.berr = b; e.chk_bus = cb; e.we = we;
    e.addr = ad; e.be = be; e.wd = wd; e.chk_rd = cr; e.rd = rd;
    return e;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] ld, logic [1:0] o, logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * o);
    case (ld)
      3'd0:    return ((s & 32'hFF) >= 32'd128) ? (s & 32'hFF) + 32'hFFFFFF00 : (s & 32'hFF);
      3'd1:    return ((s & 32'hFFFF) >= 32'd32768) ? (s & 32'hFFFF) + 32'hFFFF0000 : (s & 32'hFFFF);
      3'd2:    return w;
      3'd3:    return s & 32'hFF;
      3'd4:    return s & 32'hFFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      miss++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    pin_t p;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("mem_req", 32'(mem_req), 32'(e.req));
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
      chk("bus_err", 32'(bus_err), 32'(e.berr));
      if (e.chk_bus) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_be", 32'(mem_be), 32'(e.be));
        chk("mem_wdata", mem_wdata, e.wd);
      end
      if (e.chk_rd) chk("rdata", rdata, e.rd);
    end
    if (stall) stall_run++;
    else if (stall_run > 0) begin
      stall_len = stall_run;
      stall_run = 0;
      cap_rd    = rdata;
    end
    if (mem_req) begin
      req_run++;
      req_total++;
      cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wdata; cap_we = mem_we;
    end else if (req_run > 0) begin
      req_len = req_run;
      req_run = 0;
    end
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      case (p.kind)
        P_STALL:  chk("pin_stall_cycles", 32'(stall_len), p.val);
        P_REQ:    chk("pin_req_cycles", 32'(req_len), p.val);
        P_RD:     chk("pin_rdata", cap_rd, p.val);
        P_BE:     chk("pin_be", 32'(cap_be), p.val);
        P_ADDR:   chk("pin_addr", cap_addr, p.val);
        P_WD:     chk("pin_wdata", cap_wd, p.val);
        P_WE:     chk("pin_we", 32'(cap_we), p.val);
        default:  chk("pin_req_total", 32'(req_total), p.val);
      endcase
    end
  end

  task automatic pin(input int kind, input logic [31:0] val);
    pin_t p;
    p.kind = kind; p.val = val;
    pin_q.push_back(p);
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b1; load = 3'b000; store = 2'b00; addr = 32'h0; wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
  endtask

  task automatic push_idle();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0));
    @(posedge clk); #1;
  endtask

  // one instruction: gd = cycles gnt held low, rvd = cycles from gnt to rvalid, nogo = never grant
  task automatic do_access(input logic rd, input logic wrn, input logic [2:0] ld, input logic [1:0] st,
                           input logic [31:0] a, input logic [31:0] wd, input int gd, input int rvd,
                           input logic [31:0] word, input logic nogo);
    int n, k;
    logic legal, g, tmo, timed;
    logic [3:0] be;
    logic [31:0] wexp, rexp;
    n = 0;
    if (rd) begin
      if (ld == 3'd0 || ld == 3'd3) n = 1;
      else if (ld == 3'd1 || ld == 3'd4) n = 2;
      else if (ld == 3'd2) n = 4;
    end else begin
      if (st == 2'd0) n = 1;
      else if (st == 2'd1) n = 2;
      else if (st == 2'd2) n = 4;
    end
    legal = (n != 0) && !(rd && !wrn) && ((int'(a[1:0]) % n) == 0);
    be    = 4'(((1 << n) - 1) << int'(a[1:0]));
    if (rd)          wexp = 32'h0;
    else if (n == 1) wexp = {24'h0, wd[7:0]} * 32'h01010101;
    else if (n == 2) wexp = {16'h0, wd[15:0]} * 32'h00010001;
    else             wexp = wd;
    rexp = m_load(ld, a[1:0], word);
    rd_en = rd; wr_en = wrn; load = ld; store = st; addr = a; wdata = wd;
    if (!legal) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0));
      @(posedge clk); #1;
      idle_inputs();
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0));
      @(posedge clk); #1;
      return;
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0));
    @(posedge clk); #1;
    addr = a ^ 32'h5A5A5A5B; wdata = ~wd; load = 3'b111; store = 2'b11;
    timed = 1'b0; k = 0;
    for (int i = 0; i < TO; i++) begin
      k = i;
      g = !nogo && (i == gd);
      mem_gnt = g; mem_rvalid = !g && (gd > 0);
      tmo = (i == TO - 1) && !(g && !rd);
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, tmo, 1'b1, !rd, {a[31:2], 2'b00}, be, wexp, 1'b0, 32'h0));
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (tmo) begin timed = 1'b1; break; end
      if (g) break;
    end
    if (!timed && rd) begin
      for (int j = 1; j <= rvd; j++) begin
        mem_rvalid = (j == rvd);
        mem_gnt    = (j != rvd);
        mem_rdata  = (j == rvd) ? word : 32'hDEADBEEF;
        tmo = ((k + j) == TO - 1) && (j != rvd);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, tmo, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0));
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hDEADBEEF;
        if (tmo) begin timed = 1'b1; break; end
      end
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
                       rd || timed, timed ? 32'h0 : rexp));
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rd_en = 1'b1;
    repeat (2) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    idle_inputs();
    push_idle();

    do_access(1'b1, 1'b1, 3'd0, 2'd0, 32'h103, 32'h0, 0, 1, 32'h80FF1234, 1'b0);
    pin(P_STALL, 32'd3); pin(P_ADDR, 32'h100); pin(P_BE, 32'h8); pin(P_RD, 32'hFFFFFF80);
    push_idle();

    do_access(1'b1, 1'b1, 3'd4, 2'd0, 32'h002, 32'h0, 0, 1, 32'h8001ABCD, 1'b0);
    pin(P_BE, 32'hC); pin(P_RD, 32'h00008001);
    push_idle();

    do_access(1'b0, 1'b0, 3'd0, 2'd1, 32'h22, 32'h0000ABCD, 0, 1, 32'h0, 1'b0);
    pin(P_WE, 32'd1); pin(P_BE, 32'hC); pin(P_WD, 32'hABCDABCD); pin(P_STALL, 32'd2);
    push_idle();

    do_access(1'b1, 1'b1, 3'd2, 2'd0, 32'h41, 32'h0, 0, 1, 32'h0, 1'b0);
    pin(P_REQTOT, 32'd3);
    push_idle();

    do_access(1'b1, 1'b1, 3'd2, 2'd0, 32'h80, 32'h0, 3, 2, 32'hCAFEF00D, 1'b0);
    pin(P_REQ, 32'd4); pin(P_STALL, 32'd7); pin(P_RD, 32'hCAFEF00D);
    push_idle();

    do_access(1'b1, 1'b1, 3'd1, 2'd0, 32'h10, 32'h0, 0, 1, 32'h0, 1'b1);
    pin(P_REQ, 32'd8); pin(P_RD, 32'h0);
    push_idle();

    // reset while waiting for read data; the late rvalid must be dropped
    rd_en = 1'b1; wr_en = 1'b1; load = 3'd2; addr = 32'h40;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0));
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h0));
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst_n = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0));
    @(posedge clk); #1;
    rst_n = 1'b1; idle_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0));
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0));
    @(posedge clk); #1;

    do_access(1'b1, 1'b1, 3'd0, 2'd0, 32'h200, 32'h0, 0, 1, 32'h7F80FF01, 1'b0);
    do_access(1'b1, 1'b1, 3'd0, 2'd0, 32'h201, 32'h0, 0, 1, 32'h7F80FF01, 1'b0);
    do_access(1'b1, 1'b1, 3'd0, 2'd0, 32'h203, 32'h0, 1, 3, 32'h7F80FF01, 1'b0);
    do_access(1'b1, 1'b1, 3'd3, 2'd0, 32'h201, 32'h0, 0, 1, 32'h7F80FF01, 1'b0);
    do_access(1'b1, 1'b1, 3'd1, 2'd0, 32'h302, 32'h0, 0, 1, 32'h9ABC1234, 1'b0);
    do_access(1'b1, 1'b1, 3'd1, 2'd0, 32'h300, 32'h0, 2, 1, 32'h9ABC1234, 1'b0);
    do_access(1'b0, 1'b0, 3'd0, 2'd0, 32'h1003, 32'h12345678, 0, 1, 32'h0, 1'b0);
    do_access(1'b0, 1'b0, 3'd0, 2'd0, 32'h1001, 32'h12345678, 2, 1, 32'h0, 1'b0);
    do_access(1'b0, 1'b0, 3'd0, 2'd2, 32'h1004, 32'h12345678, 0, 1, 32'h0, 1'b0);
    do_access(1'b0, 1'b0, 3'd0, 2'd1, 32'h1000, 32'h0000BEEF, 0, 1, 32'h0, 1'b1);
    do_access(1'b1, 1'b1, 3'd5, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0);
    do_access(1'b0, 1'b0, 3'd0, 2'd3, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0);
    do_access(1'b1, 1'b0, 3'd2, 2'd2, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0);
    do_access(1'b0, 1'b0, 3'd0, 2'd1, 32'h1001, 32'h0, 0, 1, 32'h0, 1'b0);
    do_access(1'b1, 1'b1, 3'd4, 2'd0, 32'h3, 32'h0, 0, 1, 32'h0, 1'b0);

    repeat (3) push_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
